apb_uart_fifo_bridge: RTL and testbench
=======================================

# apb_uart_fifo_bridge

APB slave bridging an APB master to a UART core through buffered TX and RX paths. It replaces single-entry command/data handling with:
- parametrised-depth FIFOs per direction,
- a memory-mapped register file (data, status, control, levels),
- error reporting on `pslverr` and a level/overrun interrupt.

It sits between the APB interconnect and the UART valid/ready ports.

## Interface
- `ADDR_WIDTH`, default 8: APB address width.
- `DATA_WIDTH`, default 8: APB and UART data width; must be at least 8.
- `FIFO_DEPTH`, default 16: entries per FIFO; must be a power of two and at least 2.
- `PTR_WIDTH`, default `$clog2(FIFO_DEPTH)`: FIFO index width; level counters are `PTR_WIDTH+1` bits.

Ports:
- `pclk` in 1: single clock for the whole block.
- `prst` in 1: reset, asynchronous, active-high.
- `paddr` in `ADDR_WIDTH`: byte address.
- `pselx` in 1: APB select.
- `penable` in 1: APB enable.
- `pwrite` in 1: 1 = write.
- `pwdata` in `DATA_WIDTH`: write data.
- `pready` out 1: transfer complete.
- `prdata` out `DATA_WIDTH`: read data.
- `pslverr` out 1: transfer error.
- `rx_valid` in 1: UART RX byte available.
- `rx_ready` out 1: bridge accepts the RX byte.
- `rx_data` in `DATA_WIDTH`: RX byte.
- `tx_valid` out 1: TX byte offered to the UART.
- `tx_ready` in 1: UART accepts the TX byte.
- `tx_data` out `DATA_WIDTH`: TX byte.
- `irq` out 1: interrupt, level-sensitive.

## Operation
Register map (full `paddr` compare):
- `0x00` TXDATA: write-only; a write pushes to the TX FIFO.
- `0x04` RXDATA: read-only; a read pops the RX FIFO.
- `0x08` STATUS: read/W1C.
  - bit0 `tx_empty`, bit1 `tx_full`, bit2 `rx_empty`, bit3 `rx_full`.
  - bit4 `rx_overrun`: sticky; writing bit4=1 clears it.
  - Other bits read 0.
- `0x0C` CTRL: read/write, reset 0x03.
  - bit0 `tx_en`, bit1 `rx_en`, bit2 `irq_rx_en`, bit3 `irq_tx_en`.
  - bit4 `flush_tx` and bit5 `flush_rx`: self-clearing, always read 0.
- `0x10` TXLVL: read-only; TX occupancy, 0..`FIFO_DEPTH`, zero-extended.
- `0x14` RXLVL: read-only; RX occupancy, 0..`FIFO_DEPTH`, zero-extended.

Error responses:
- Unmapped address, write to a read-only register, or read of TXDATA: `pslverr`=1, no side effect, `prdata`=0.
- TXDATA write while `tx_full`: `pslverr`=1, data dropped.
- RXDATA read while `rx_empty`: `pslverr`=1, `prdata`=0, no pop.

APB FSM:
- IDLE → SETUP on `pselx` & !`penable`.
- SETUP → WAIT on `pselx` & `penable`.
- WAIT → RESP: one wait cycle, decode registered.
- RESP → SETUP if `pselx` & !`penable`, otherwise → IDLE.
- `pselx` low in SETUP or WAIT: return to IDLE, no side effect.

TX path:
- `tx_valid` = `tx_en` & !`tx_empty`.
- `tx_data` = FIFO head while `tx_valid`, else 0.
- Pop on `tx_valid` & `tx_ready`.

RX path:
- `rx_ready` = `rx_en`.
- Push on `rx_valid` & `rx_ready` when !`rx_full`.
- If `rx_full`: byte dropped and `rx_overrun` set.

Full/empty and pointer rules:
- Full/empty are evaluated at the start of the cycle. A push into a full FIFO is rejected even if a pop occurs on the same edge.
- A simultaneous push and pop on a non-full, non-empty FIFO keeps the level unchanged.
- Pointers are `PTR_WIDTH+1` bits and wrap modulo 2·`FIFO_DEPTH`.
- Full when the indices are equal and the MSBs differ; empty when the pointers are equal.

Flush and clear priority:
- A flush resets that FIFO's pointers at the edge of the CTRL write and wins over any same-edge push or pop.
- A same-edge `rx_overrun` set and W1C clear: set wins.

Interrupt:
- `irq` is registered: (`irq_rx_en` & !`rx_empty`) | (`irq_tx_en` & `tx_empty`) | `rx_overrun`.

## Timing
- Reset values:
  - Outputs: `pready`=0, `prdata`=0, `pslverr`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1, `irq`=0.
  - State: FSM IDLE, both FIFOs empty, CTRL=0x03, `rx_overrun`=0.
- Reset mid-transfer aborts the transfer; FIFO contents are discarded.
- Every APB transfer takes SETUP + 2 access cycles; `pready` is high for exactly one cycle, in RESP.
- `prdata` and `pslverr` are valid only while `pready`=1; `pslverr` returns to 0 after RESP.
- Register and FIFO side effects (push, pop, CTRL write, W1C) take place on the edge ending RESP.
- Latency, TXDATA write to UART: `tx_valid` rises 1 cycle after the RESP edge (FIFO empty, `tx_en`=1).
- Latency, UART RX push to APB: the byte is visible in RXLVL and popable from the next cycle.
- `irq` lags its condition by 1 cycle.

## Test plan
- Reset check: assert `prst` for 3 cycles, then read CTRL, STATUS, TXLVL → 0x03, 0x05, 0x00. Each read has exactly one wait state with `pready` high for 1 cycle.
- TX fill/drain:
  - Hold `tx_ready`=0 and write 0xA0..0xAF to TXDATA (`FIFO_DEPTH`=16). TXLVL=16, STATUS bit1=1.
  - A 17th write → `pslverr`=1, TXLVL stays 16.
  - Then `tx_ready`=1 → `tx_data` sequence 0xA0..0xAF on 16 consecutive cycles, then `tx_valid`=0.
- RX overrun:
  - Push 17 bytes 0x10..0x20 on `rx_valid` with no pops → RXLVL=16, STATUS bit4=1, `irq`=1. Reads return 0x10..0x1F.
  - A 17th read → `pslverr`=1, `prdata`=0.
  - Write STATUS 0x10 → bit4 clears.
- Simultaneous TX push and pop: at level 3, an APB TXDATA write lands on the same edge as a `tx_valid`&`tx_ready` pop → TXLVL stays 3 and ordering is preserved.
- Flush and errors:
  - CTRL write 0x33 while TX holds 5 bytes → TXLVL=0, `tx_valid`=0 next cycle, CTRL reads 0x03.
  - Write to 0x04, read of 0x00, and access to 0x18 each → `pslverr`=1 with no state change.
- Reset mid-operation: assert `prst` during WAIT of a TXDATA write with 4 bytes queued → no push occurs; all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/apb_uart_fifo_bridge.sv
// apb_uart_fifo_bridge: APB slave with TX/RX FIFOs, register file and irq between APB and a UART valid/ready core.
// Transfers run SETUP -> WAIT -> RESP; all register and FIFO side effects commit on the edge ending RESP.
module apb_uart_fifo_bridge_fifo #(
    parameter int W = 8,
    parameter int D = 16,
    parameter int P = $clog2(D)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [P:0]   level,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [D];
    logic [P:0]   wp, rp;
    assign empty = wp == rp;
    assign full  = wp[P-1:0] == rp[P-1:0] && wp[P] != rp[P];
    assign level = wp - rp;
    assign head  = mem[rp[P-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (push && !full && !flush) mem[wp[P-1:0]] <= din;
endmodule

module apb_uart_fifo_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  irq
);
    localparam logic [ADDR_WIDTH-1:0] A_TX = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] A_RX = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] A_ST = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] A_CT = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] A_TL = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] A_RL = ADDR_WIDTH'('h14);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;
    state_t state;

    logic [3:0]            ctrl;
    logic                  overrun;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  s_push, s_pop, s_ctrl, s_w1c;
    logic                  d_err, d_push, d_pop, d_ctrl, d_w1c;
    logic [DATA_WIDTH-1:0] d_rdata, tx_head, rx_head, status;
    logic [PTR_WIDTH:0]    tx_level, rx_level;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  flush_tx, flush_rx, rx_fire;

    assign tx_valid = ctrl[0] && !tx_empty;
    assign tx_data  = tx_valid ? tx_head : '0;
    assign rx_ready = ctrl[1];
    assign rx_fire  = rx_valid && rx_ready;
    assign flush_tx = s_ctrl && wdata[4];
    assign flush_rx = s_ctrl && wdata[5];
    assign status   = DATA_WIDTH'({overrun, rx_full, rx_empty, tx_full, tx_empty});

    apb_uart_fifo_bridge_fifo #(.W(DATA_WIDTH), .D(FIFO_DEPTH), .P(PTR_WIDTH)) u_tx (
        .clk(pclk), .rst(prst), .push(s_push), .pop(tx_valid && tx_ready), .flush(flush_tx),
        .din(wdata), .head(tx_head), .level(tx_level), .empty(tx_empty), .full(tx_full)
    );

    apb_uart_fifo_bridge_fifo #(.W(DATA_WIDTH), .D(FIFO_DEPTH), .P(PTR_WIDTH)) u_rx (
        .clk(pclk), .rst(prst), .push(rx_fire), .pop(s_pop), .flush(flush_rx),
        .din(rx_data), .head(rx_head), .level(rx_level), .empty(rx_empty), .full(rx_full)
    );

    // Decode of the live bus during WAIT; only TX pushes and RX pops come from APB, so the result holds through RESP.
    always_comb begin
        d_err   = 1'b0;
        d_rdata = '0;
        d_push  = 1'b0;
        d_pop   = 1'b0;
        d_ctrl  = 1'b0;
        d_w1c   = 1'b0;
        if (paddr == A_TX) begin
            d_err  = !pwrite || tx_full;
            d_push = !d_err;
        end else if (paddr == A_RX) begin
            d_err   = pwrite || rx_empty;
            d_pop   = !d_err;
            d_rdata = d_err ? '0 : rx_head;
        end else if (paddr == A_ST) begin
            d_w1c   = pwrite;
            d_rdata = pwrite ? '0 : status;
        end else if (paddr == A_CT) begin
            d_ctrl  = pwrite;
            d_rdata = pwrite ? '0 : DATA_WIDTH'(ctrl);
        end else if (paddr == A_TL) begin
            d_err   = pwrite;
            d_rdata = pwrite ? '0 : DATA_WIDTH'(tx_level);
        end else if (paddr == A_RL) begin
            d_err   = pwrite;
            d_rdata = pwrite ? '0 : DATA_WIDTH'(rx_level);
        end else begin
            d_err = 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge prst)
        if (prst) begin
            state   <= IDLE;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            wdata   <= '0;
            s_push  <= 1'b0;
            s_pop   <= 1'b0;
            s_ctrl  <= 1'b0;
            s_w1c   <= 1'b0;
        end else begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            s_push  <= 1'b0;
            s_pop   <= 1'b0;
            s_ctrl  <= 1'b0;
            s_w1c   <= 1'b0;
            case (state)
                IDLE:  state <= (pselx && !penable) ? SETUP : IDLE;
                SETUP: state <= !pselx ? IDLE : penable ? WAIT : SETUP;
                WAIT:
                    if (!pselx) state <= IDLE;
                    else begin
                        state   <= RESP;
                        pready  <= 1'b1;
                        pslverr <= d_err;
                        prdata  <= d_rdata;
                        wdata   <= pwdata;
                        s_push  <= d_push;
                        s_pop   <= d_pop;
                        s_ctrl  <= d_ctrl;
                        s_w1c   <= d_w1c;
                    end
                default: state <= (pselx && !penable) ? SETUP : IDLE;
            endcase
        end

    always_ff @(posedge pclk or posedge prst)
        if (prst) begin
            ctrl    <= 4'h3;
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (s_ctrl) ctrl <= wdata[3:0];
            overrun <= (rx_fire && rx_full) || (overrun && !(s_w1c && wdata[4]));
            irq     <= (ctrl[2] && !rx_empty) || (ctrl[3] && tx_empty) || overrun;
        end
endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// tb_apb_uart_fifo_bridge: scoreboard bench; TX bytes are queued on accepted writes and matched at the UART side,
// RX bytes are queued when pushed by the UART and matched on RXDATA reads.
module tb_apb_uart_fifo_bridge;
    logic       pclk = 0, prst = 1;
    logic [7:0] paddr = 0, pwdata = 0, rx_data = 0;
    logic       pselx = 0, penable = 0, pwrite = 0, rx_valid = 0, tx_ready = 0;
    logic       pready, pslverr, rx_ready, tx_valid, irq;
    logic [7:0] prdata, tx_data;
    int         total = 0, bad = 0, wait_n = 0;
    logic       pready_after;
    logic [7:0] rd;
    logic       er;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    apb_uart_fifo_bridge dut (
        .pclk(pclk), .prst(prst), .paddr(paddr), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge pclk)
        if (!prst && tx_valid && tx_ready) begin
            if (txq.size() == 0) check("tx_extra", 1, 0);
            else check("tx_data", tx_data, txq.pop_front());
        end

    task automatic apb(input logic [7:0] a, input logic w, input logic [7:0] d, input logic pop_resp,
                       output logic [7:0] r, output logic e);
        @(posedge pclk) #1;
        pselx = 1; penable = 0; paddr = a; pwrite = w; pwdata = d;
        @(posedge pclk) #1;
        penable = 1;
        wait_n = 0;
        r = 0; e = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk) #1;
            wait_n++;
            if (pready) break;
        end
        if (!pready) check("timeout", 0, 1);
        r = prdata; e = pslverr;
        if (pop_resp) tx_ready = 1;
        @(posedge pclk) #1;
        pselx = 0; penable = 0;
        if (pop_resp) tx_ready = 0;
        pready_after = pready;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic exp_err);
        apb(a, 1, d, 0, rd, er);
        check($sformatf("werr_%0h", a), er, exp_err);
    endtask

    task automatic rdchk(input logic [7:0] a, input logic [7:0] exp, input logic exp_err);
        apb(a, 0, 0, 0, rd, er);
        check($sformatf("rerr_%0h", a), er, exp_err);
        check($sformatf("rdata_%0h", a), rd, exp);
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", pready, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_rxr", rx_ready, 1);
        check("rst_irq", irq, 0);
        prst = 0;
        rdchk(8'h0C, 8'h03, 0);
        check("wait_cycles", wait_n, 2);
        check("pready_one", pready_after, 0);
        rdchk(8'h08, 8'h05, 0);
        rdchk(8'h10, 8'h00, 0);

        // TX fill / overflow / drain
        for (int i = 0; i < 16; i++) begin
            txq.push_back(8'hA0 + 8'(i));
            wr(8'h00, 8'hA0 + 8'(i), 0);
        end
        rdchk(8'h10, 8'h10, 0);
        rdchk(8'h08, 8'h06, 0);
        wr(8'h00, 8'hEE, 1);
        rdchk(8'h10, 8'h10, 0);
        @(posedge pclk) #1 tx_ready = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            check("drain_valid", tx_valid, 1);
        end
        @(negedge pclk);
        check("drain_done", tx_valid, 0);
        check("txq_empty", txq.size(), 0);
        tx_ready = 0;

        // RX overrun
        for (int i = 0; i < 17; i++) begin
            @(posedge pclk) #1;
            rx_valid = 1; rx_data = 8'h10 + 8'(i);
            if (rxq.size() < 16) rxq.push_back(rx_data);
        end
        @(posedge pclk) #1 rx_valid = 0;
        rdchk(8'h14, 8'h10, 0);
        rdchk(8'h08, 8'h19, 0);
        check("ovr_irq", irq, 1);
        while (rxq.size() > 0) rdchk(8'h04, rxq.pop_front(), 0);
        rdchk(8'h04, 8'h00, 1);
        wr(8'h08, 8'h10, 0);
        rdchk(8'h08, 8'h05, 0);
        repeat (2) @(posedge pclk);
        #1 check("irq_clear", irq, 0);

        // simultaneous push and pop at level 3
        for (int i = 0; i < 3; i++) begin
            txq.push_back(8'hB0 + 8'(i));
            wr(8'h00, 8'hB0 + 8'(i), 0);
        end
        txq.push_back(8'hB3);
        apb(8'h00, 1, 8'hB3, 1, rd, er);
        check("sim_err", er, 0);
        rdchk(8'h10, 8'h03, 0);
        @(posedge pclk) #1 tx_ready = 1;
        repeat (3) @(negedge pclk);
        @(negedge pclk);
        check("sim_done", tx_valid, 0);
        check("sim_txq", txq.size(), 0);
        tx_ready = 0;

        // flush
        for (int i = 0; i < 5; i++) begin
            txq.push_back(8'hC0 + 8'(i));
            wr(8'h00, 8'hC0 + 8'(i), 0);
        end
        wr(8'h0C, 8'h33, 0);
        txq.delete();
        @(negedge pclk);
        check("flush_txv", tx_valid, 0);
        rdchk(8'h10, 8'h00, 0);
        rdchk(8'h0C, 8'h03, 0);

        // error accesses with no side effect
        @(posedge pclk) #1 rx_valid = 1; rx_data = 8'h55;
        @(posedge pclk) #1 rx_valid = 0;
        wr(8'h04, 8'h99, 1);
        rdchk(8'h00, 8'h00, 1);
        rdchk(8'h18, 8'h00, 1);
        wr(8'h18, 8'hFF, 1);
        wr(8'h10, 8'h07, 1);
        rdchk(8'h14, 8'h01, 0);
        rdchk(8'h0C, 8'h03, 0);
        rdchk(8'h10, 8'h00, 0);
        rdchk(8'h04, 8'h55, 0);

        // reset during WAIT of a TXDATA write
        for (int i = 0; i < 4; i++) begin
            txq.push_back(8'hD0 + 8'(i));
            wr(8'h00, 8'hD0 + 8'(i), 0);
        end
        wr(8'h0C, 8'h0B, 0);
        @(posedge pclk) #1;
        pselx = 1; penable = 0; paddr = 8'h00; pwrite = 1; pwdata = 8'hD4;
        @(posedge pclk) #1 penable = 1;
        @(posedge pclk) #1 prst = 1;
        #1;
        check("mid_pready", pready, 0);
        check("mid_prdata", prdata, 0);
        check("mid_pslverr", pslverr, 0);
        check("mid_txv", tx_valid, 0);
        check("mid_txd", tx_data, 0);
        check("mid_rxr", rx_ready, 1);
        check("mid_irq", irq, 0);
        pselx = 0; penable = 0;
        txq.delete();
        repeat (2) @(posedge pclk);
        #1 prst = 0;
        rdchk(8'h10, 8'h00, 0);
        rdchk(8'h0C, 8'h03, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
